// File: rtl/i2s_capture_scheduler.sv
// i2s_capture_scheduler: round-robin merge of N_CH one-word capture buffers into a tagged valid/ready stream with enable/drain sequencing and sticky overflow
module i2s_capture_scheduler #(
  parameter int N_CH = 4,
  parameter int DATA_W = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [N_CH-1:0]           ch_mask_i,
  input  logic [N_CH*DATA_W-1:0]    ch_data_i,
  input  logic [N_CH-1:0]           ch_valid_i,
  output logic [DATA_W-1:0]         m_data_o,
  output logic [$clog2(N_CH)-1:0]   m_ch_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [N_CH-1:0]           overflow_o,
  input  logic                      clear_ovf_i,
  output logic                      busy_o
);
  localparam int CH_W = $clog2(N_CH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [N_CH-1:0] pend, cap, gnt, load, ovf_set;
  logic [DATA_W-1:0] hold [N_CH];
  logic [CH_W-1:0] rr_ptr, g;
  logic [CH_W:0] s;
  logic found, free;
  always_comb begin
    s = '0;
    g = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      s = {1'b0, rr_ptr} + (CH_W+1)'(i);
      s = (s >= (CH_W+1)'(N_CH)) ? s - (CH_W+1)'(N_CH) : s;
      if (!found && pend[s[CH_W-1:0]]) begin
        found = 1'b1;
        g = s[CH_W-1:0];
      end
    end
  end
  assign free = !m_valid_o || m_ready_i;
  assign gnt = (free && found) ? (N_CH'(1) << g) : '0;
  assign cap = (state == RUN) ? (ch_valid_i & ch_mask_i) : '0;
  assign load = cap & (~pend | gnt);
  assign ovf_set = cap & pend & ~gnt;
  assign busy_o = state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (enable_i ? RUN : IDLE) :
               (state == RUN)  ? (enable_i ? RUN : DRAIN) :
               enable_i ? RUN : (!(|pend) && !m_valid_o) ? IDLE : DRAIN;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      pend <= '0;
      rr_ptr <= '0;
      m_valid_o <= 1'b0;
      m_data_o <= '0;
      m_ch_o <= '0;
      overflow_o <= '0;
      for (int k = 0; k < N_CH; k++) hold[k] <= '0;
    end else begin
      state <= state_nx;
      pend <= (pend & ~gnt) | cap;
      overflow_o <= (clear_ovf_i ? '0 : overflow_o) | ovf_set;
      for (int k = 0; k < N_CH; k++) if (load[k]) hold[k] <= ch_data_i[k*DATA_W +: DATA_W];
      if (free) begin
        m_valid_o <= found;
        if (found) begin
          m_data_o <= hold[g];
          m_ch_o <= g;
          rr_ptr <= (g == CH_W'(N_CH-1)) ? '0 : g + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/i2s_capture_scheduler.md
# i2s_capture_scheduler

Round-robin scheduler that shares one downstream sample stream between `N_CH` I2S capture channels, each an `i2s_capture_24` instance delivering a 24-bit word with a one-cycle `valid` pulse. It buffers one pending word per channel, arbitrates fairly among channels with pending words, and presents a registered valid/ready stream tagged with the channel index. It also owns capture enable/drain sequencing and per-channel overflow reporting for the microphone array front end.

## Interface
- `N_CH`, 4, number of capture channels (2..16); channel index width `CH_W = $clog2(N_CH)` (localparam).
- `DATA_W`, 24, sample width.

- `clk_i`  in  1  system clock (same domain as capture instances)
- `rst_i`  in  1  reset, asynchronous, active-high
- `enable_i`  in  1  capture enable; deassertion starts drain
- `ch_mask_i`  in  N_CH  per-channel accept mask
- `ch_data_i`  in  N_CH*DATA_W  channel k data at bits [k*DATA_W +: DATA_W]
- `ch_valid_i`  in  N_CH  one-cycle pulse per channel word
- `m_data_o`  out  DATA_W  output sample
- `m_ch_o`  out  CH_W  channel index of `m_data_o`
- `m_valid_o`  out  1  output valid
- `m_ready_i`  in  1  downstream ready
- `overflow_o`  out  N_CH  sticky per-channel overflow
- `clear_ovf_i`  in  1  clears all `overflow_o` bits
- `busy_o`  out  1  high in RUN or DRAIN

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when `enable_i`=1.
  - RUN -> DRAIN when `enable_i`=0.
  - DRAIN -> RUN when `enable_i`=1.
  - DRAIN -> IDLE when no pending bits and `m_valid_o`=0.
- Capture happens only in RUN: `ch_valid_i[k] & ch_mask_i[k]` loads `hold[k]` and sets `pend[k]`. Valid pulses in IDLE/DRAIN or on masked channels are ignored: no load, no overflow.
- Overflow: capture on channel k while `pend[k]`=1 and k is not granted in the same cycle.
  - New word is dropped; `hold[k]` keeps the old word.
  - `overflow_o[k]` is set.
- Capture and grant of the same channel in the same cycle: the old word goes to output, the new word loads `hold[k]`, `pend[k]` stays 1, no overflow.
- Output slot is free when `m_valid_o`=0 or `m_ready_i`=1. When free and any pend=1, grant one channel:
  - `m_data_o`<=`hold[g]`, `m_ch_o`<=g, `m_valid_o`<=1, `pend[g]`<=0.
  - If free and nothing pending, `m_valid_o`<=0.
- Round-robin: search starts at `rr_ptr` and wraps modulo `N_CH`; after a grant, `rr_ptr`<=(g+1) mod `N_CH`.
- While `m_valid_o`=1 and `m_ready_i`=0, `m_data_o` and `m_ch_o` are held stable.
- `clear_ovf_i` clears all `overflow_o` bits. If a new overflow occurs in the same cycle, that bit sets; set wins.
- `ch_mask_i` changes do not clear existing pending words; they still drain.

## Timing
- Reset values (asynchronous): state=IDLE, `pend`=0, `hold`=0, `rr_ptr`=0, `m_valid_o`=0, `m_data_o`=0, `m_ch_o`=0, `overflow_o`=0, `busy_o`=0.
- Reset mid-operation discards all pending and output words immediately.
- Latency: `ch_valid_i` at cycle t -> `pend` set at t+1 -> `m_valid_o` at t+2, provided the slot is free and no other channel wins.
- Throughput: one word per cycle while `m_ready_i`=1.
- `busy_o` is combinational from state; it rises the cycle after `enable_i` is first sampled high.
- IDLE->RUN: the first capture is accepted the cycle after entry. A `ch_valid_i` pulse in the same cycle as `enable_i` rising is ignored.

## Test plan
- 4 channels, all masked in, `m_ready_i`=1, simultaneous pulses with data 0x000001..0x000004 -> outputs ch 0,1,2,3 on consecutive cycles, first at t+2.
- Hold `m_ready_i`=0 for 10 cycles with ch2 pending and output holding ch1 -> `m_data_o`/`m_ch_o` stable, no grant.
- Second ch1 pulse 0xABCDEF while ch1 still pending -> ch1 0xABCDEF is not in the stream, `overflow_o`=4'b0010, old ch1 word is still delivered.
- `clear_ovf_i` -> `overflow_o` clears.
- Continuous pulses on all channels with `m_ready_i` toggling -> every channel's grant count differs by at most 1.
- Deassert `enable_i` with 3 words pending -> DRAIN, 3 words emitted, then IDLE with `busy_o`=0; pulses during drain are ignored.
- Assert `rst_i` mid-stream with `m_valid_o`=1 -> all outputs 0 immediately, no stale word after release.
